// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The master modport drives decode/stage status; the slave modport (the controller) returns pipeline control.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [4:0]       id_rd;
  logic             id_regwrite;
  logic             id_load;
  logic             ex_redirect;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_we;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_flush;
  logic             pipe_hold;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             mem_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_regwrite, id_load,
           ex_redirect, mem_req, mem_ready,
    input  pc_we, ifid_we, ifid_flush, idex_flush, pipe_hold, fwd_a, fwd_b,
           mem_busy, stall_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_regwrite, id_load,
           ex_redirect, mem_req, mem_ready,
    output pc_we, ifid_we, ifid_flush, idex_flush, pipe_hold, fwd_a, fwd_b,
           mem_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stall, redirect flush, memory-wait freeze,
// EX operand forwarding from shadow copies of EX/MEM/WB destination info, and a saturating stall counter.
module hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  typedef enum logic {S_RUN, S_WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;

  logic [4:0]       ex_rs1_q, ex_rs2_q, ex_rd_q;
  logic             ex_regwrite_q, ex_load_q;
  logic [4:0]       mem_rd_q, wb_rd_q;
  logic             mem_regwrite_q, wb_regwrite_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic             freeze;
  logic             load_use;
  logic             pc_we, ifid_we, ifid_flush, idex_flush;
  logic [1:0]       fwd_a, fwd_b;

  assign freeze = bus.mem_req & ~bus.mem_ready;

  // x0 in EX never stalls: ex_rd must be nonzero.
  assign load_use = ex_load_q & ex_regwrite_q & (ex_rd_q != 5'd0) &
                    ((bus.id_rs1_used & (bus.id_rs1 == ex_rd_q)) |
                     (bus.id_rs2_used & (bus.id_rs2 == ex_rd_q)));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (freeze)        state_d = S_WAIT;
      S_WAIT:  if (bus.mem_ready) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (freeze) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
    end else if (bus.ex_redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  assign fwd_a = (mem_regwrite_q && (mem_rd_q != 5'd0) && (mem_rd_q == ex_rs1_q)) ? 2'b01 :
                 (wb_regwrite_q  && (wb_rd_q  != 5'd0) && (wb_rd_q  == ex_rs1_q)) ? 2'b10 : 2'b00;
  assign fwd_b = (mem_regwrite_q && (mem_rd_q != 5'd0) && (mem_rd_q == ex_rs2_q)) ? 2'b01 :
                 (wb_regwrite_q  && (wb_rd_q  != 5'd0) && (wb_rd_q  == ex_rs2_q)) ? 2'b10 : 2'b00;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_we && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_rs1_q       <= '0;
      ex_rs2_q       <= '0;
      ex_rd_q        <= '0;
      ex_regwrite_q  <= 1'b0;
      ex_load_q      <= 1'b0;
      mem_rd_q       <= '0;
      mem_regwrite_q <= 1'b0;
      wb_rd_q        <= '0;
      wb_regwrite_q  <= 1'b0;
    end else if (!freeze) begin
      if (idex_flush) begin
        ex_rs1_q      <= '0;
        ex_rs2_q      <= '0;
        ex_rd_q       <= '0;
        ex_regwrite_q <= 1'b0;
        ex_load_q     <= 1'b0;
      end else begin
        ex_rs1_q      <= bus.id_rs1;
        ex_rs2_q      <= bus.id_rs2;
        ex_rd_q       <= bus.id_rd;
        ex_regwrite_q <= bus.id_regwrite;
        ex_load_q     <= bus.id_load;
      end
      mem_rd_q       <= ex_rd_q;
      mem_regwrite_q <= ex_regwrite_q;
      wb_rd_q        <= mem_rd_q;
      wb_regwrite_q  <= mem_regwrite_q;
    end
  end

  assign bus.pc_we      = pc_we;
  assign bus.ifid_we    = ifid_we;
  assign bus.ifid_flush = ifid_flush;
  assign bus.idex_flush = idex_flush;
  assign bus.pipe_hold  = freeze;
  assign bus.fwd_a      = fwd_a;
  assign bus.fwd_b      = fwd_b;
  assign bus.mem_busy   = (state_q == S_WAIT);
  assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: one default-width instance and one 4-bit-counter instance.
module tb_hazard_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  hazard_ctrl_if #(.CNT_W(16)) b ();
  hazard_ctrl_if #(.CNT_W(4))  b4 ();

  hazard_ctrl #(.CNT_W(16)) dut   (.clk(clk), .rst(rst), .bus(b.slave));
  hazard_ctrl #(.CNT_W(4))  dut4  (.clk(clk), .rst(rst), .bus(b4.slave));

  // {pc_we, ifid_we, ifid_flush, idex_flush, pipe_hold}
  logic [4:0] ctl;
  assign ctl = {b.pc_we, b.ifid_we, b.ifid_flush, b.idex_flush, b.pipe_hold};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic quiet();
    b.id_rs1 = '0; b.id_rs2 = '0; b.id_rs1_used = 1'b0; b.id_rs2_used = 1'b0;
    b.id_rd = '0; b.id_regwrite = 1'b0; b.id_load = 1'b0;
    b.ex_redirect = 1'b0; b.mem_req = 1'b0; b.mem_ready = 1'b0;
    b4.id_rs1 = '0; b4.id_rs2 = '0; b4.id_rs1_used = 1'b0; b4.id_rs2_used = 1'b0;
    b4.id_rd = '0; b4.id_regwrite = 1'b0; b4.id_load = 1'b0;
    b4.ex_redirect = 1'b0; b4.mem_req = 1'b0; b4.mem_ready = 1'b0;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                        input logic u2, input logic [4:0] rd, input logic rw, input logic ld);
    b.id_rs1 = rs1; b.id_rs1_used = u1; b.id_rs2 = rs2; b.id_rs2_used = u2;
    b.id_rd = rd; b.id_regwrite = rw; b.id_load = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    quiet();
    rst = 1'b1;
    #3;
    total++; if (ctl !== 5'b11000) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 5'b11000); end
    total++; if ({b.fwd_a, b.fwd_b} !== 4'b0000) begin bad++; $display("FAIL reset_fwd got=%b exp=%b", {b.fwd_a, b.fwd_b}, 4'b0000); end
    total++; if (b.mem_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", b.mem_busy); end
    total++; if (b.stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", b.stall_cnt); end
    total++; if (b4.stall_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt4 got=%0d exp=0", b4.stall_cnt); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    #1;
    total++; if (ctl !== 5'b11000) begin bad++; $display("FAIL lu_first got=%b exp=%b", ctl, 5'b11000); end
    tick();
    set_id(5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0);
    #1;
    total++; if (ctl !== 5'b00010) begin bad++; $display("FAIL lu_stall got=%b exp=%b", ctl, 5'b00010); end
    tick();
    total++; if (ctl !== 5'b11000) begin bad++; $display("FAIL lu_release got=%b exp=%b", ctl, 5'b11000); end
    total++; if (b.fwd_a !== 2'b00) begin bad++; $display("FAIL lu_bubble_fwd got=%b exp=00", b.fwd_a); end
    total++; if (b.stall_cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt got=%0d exp=1", b.stall_cnt); end
    tick();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    total++; if ({b.fwd_a, b.fwd_b} !== 4'b1000) begin bad++; $display("FAIL lu_fwd got=%b exp=%b", {b.fwd_a, b.fwd_b}, 4'b1000); end
    tick();
    total++; if (b.stall_cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt_after got=%0d exp=1", b.stall_cnt); end
  endtask

  task automatic test_load_use_corner();
    do_reset();
    set_id(5'd2, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
    tick();
    set_id(5'd3, 1'b1, 5'd9, 1'b0, 5'd4, 1'b1, 1'b0);
    #1;
    total++; if (ctl !== 5'b11000) begin bad++; $display("FAIL lu_rs2_unused got=%b exp=%b", ctl, 5'b11000); end
    tick();
    set_id(5'd2, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
    tick();
    set_id(5'd3, 1'b1, 5'd9, 1'b1, 5'd4, 1'b1, 1'b0);
    #1;
    total++; if (ctl !== 5'b00010) begin bad++; $display("FAIL lu_rs2 got=%b exp=%b", ctl, 5'b00010); end
    tick();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    set_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);
    #1;
    total++; if (ctl !== 5'b11000) begin bad++; $display("FAIL lu_x0 got=%b exp=%b", ctl, 5'b11000); end
    tick();
  endtask

  task automatic test_redirect();
    do_reset();
    set_id(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    set_id(5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0);
    b.ex_redirect = 1'b1;
    #1;
    total++; if (ctl !== 5'b11110) begin bad++; $display("FAIL redir_vs_lu got=%b exp=%b", ctl, 5'b11110); end
    tick();
    b.ex_redirect = 1'b0;
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    total++; if (b.stall_cnt !== 16'd0) begin bad++; $display("FAIL redir_nostall got=%0d exp=0", b.stall_cnt); end
    total++; if (ctl !== 5'b11000) begin bad++; $display("FAIL redir_after got=%b exp=%b", ctl, 5'b11000); end
  endtask

  task automatic test_forward();
    do_reset();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0); tick();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0); tick();
    set_id(5'd3, 1'b1, 5'd3, 1'b1, 5'd10, 1'b1, 1'b0); tick();
    total++; if ({b.fwd_a, b.fwd_b} !== 4'b0101) begin bad++; $display("FAIL fwd_prec got=%b exp=%b", {b.fwd_a, b.fwd_b}, 4'b0101); end
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0); tick();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0); tick();
    set_id(5'd3, 1'b1, 5'd4, 1'b1, 5'd11, 1'b0, 1'b0); tick();
    total++; if ({b.fwd_a, b.fwd_b} !== 4'b1001) begin bad++; $display("FAIL fwd_wb_mem got=%b exp=%b", {b.fwd_a, b.fwd_b}, 4'b1001); end
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0); tick();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0); tick();
    set_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd12, 1'b1, 1'b0); tick();
    total++; if ({b.fwd_a, b.fwd_b} !== 4'b0000) begin bad++; $display("FAIL fwd_x0 got=%b exp=%b", {b.fwd_a, b.fwd_b}, 4'b0000); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    tick();
    set_id(5'd3, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0);
    b.mem_req = 1'b1; b.mem_ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      #1;
      total++; if (ctl !== 5'b00001) begin bad++; $display("FAIL wait_ctl%0d got=%b exp=%b", i, ctl, 5'b00001); end
      total++; if (b.mem_busy !== (i != 0)) begin bad++; $display("FAIL wait_busy%0d got=%b exp=%b", i, b.mem_busy, (i != 0)); end
      tick();
    end
    b.mem_ready = 1'b1;
    #1;
    total++; if (ctl !== 5'b11000) begin bad++; $display("FAIL wait_release got=%b exp=%b", ctl, 5'b11000); end
    total++; if (b.mem_busy !== 1'b1) begin bad++; $display("FAIL wait_busy_rel got=%b exp=1", b.mem_busy); end
    tick();
    b.mem_req = 1'b0; b.mem_ready = 1'b0;
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    total++; if (b.mem_busy !== 1'b0) begin bad++; $display("FAIL wait_run got=%b exp=0", b.mem_busy); end
    total++; if (b.stall_cnt !== 16'd3) begin bad++; $display("FAIL wait_cnt got=%0d exp=3", b.stall_cnt); end
    total++; if (b.fwd_a !== 2'b01) begin bad++; $display("FAIL wait_hold_fwd got=%b exp=01", b.fwd_a); end
  endtask

  task automatic test_freeze_redirect();
    do_reset();
    b.mem_req = 1'b1; b.mem_ready = 1'b0; b.ex_redirect = 1'b1;
    #1;
    total++; if (ctl !== 5'b00001) begin bad++; $display("FAIL frz_redir0 got=%b exp=%b", ctl, 5'b00001); end
    tick();
    total++; if (ctl !== 5'b00001) begin bad++; $display("FAIL frz_redir1 got=%b exp=%b", ctl, 5'b00001); end
    tick();
    b.mem_ready = 1'b1;
    #1;
    total++; if (ctl !== 5'b11110) begin bad++; $display("FAIL frz_redir_rel got=%b exp=%b", ctl, 5'b11110); end
    tick();
    quiet();
    #1;
    total++; if (b.stall_cnt !== 16'd2) begin bad++; $display("FAIL frz_redir_cnt got=%0d exp=2", b.stall_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    b4.mem_req = 1'b1; b4.mem_ready = 1'b0;
    repeat (10) tick();
    total++; if (b4.stall_cnt !== 4'd10) begin bad++; $display("FAIL sat_cnt10 got=%0d exp=10", b4.stall_cnt); end
    repeat (10) tick();
    total++; if (b4.stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_cnt20 got=%0d exp=15", b4.stall_cnt); end
    total++; if (b4.mem_busy !== 1'b1) begin bad++; $display("FAIL sat_busy got=%b exp=1", b4.mem_busy); end
    rst = 1'b1;
    #1;
    total++; if (b4.mem_busy !== 1'b0) begin bad++; $display("FAIL async_busy got=%b exp=0", b4.mem_busy); end
    total++; if (b4.stall_cnt !== 4'd0) begin bad++; $display("FAIL async_cnt got=%0d exp=0", b4.stall_cnt); end
    b4.mem_req = 1'b0;
    #1;
    rst = 1'b0;
    tick();
    total++; if (b4.mem_busy !== 1'b0) begin bad++; $display("FAIL async_forget got=%b exp=0", b4.mem_busy); end
    total++; if (b4.stall_cnt !== 4'd0) begin bad++; $display("FAIL async_cnt_after got=%0d exp=0", b4.stall_cnt); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_load_use();
    test_load_use_corner();
    test_redirect();
    test_forward();
    test_mem_wait();
    test_freeze_redirect();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
